// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI-lite responder terminating the memory bus, one read and one write in flight.
// Ports: clk, rst (sync, active-high); AR: araddr/arvalid/arready; R: rdata/rresp/rvalid/rready;
//        AW: awaddr/awvalid/awready; W: wdata/wstrb/wvalid/wready; B: bresp/bvalid/bready.
// Responses: 00 OKAY, 11 DECERR. Legal: 0x8000_0000..0x87FF_FFFF and UART 0xA000_03F8.
// Define SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra cycles to every access latency.
// The pmem read/write calls are served by an internal word array of 2**MEM_AW entries
// indexed by addr[MEM_AW+1:2], so the block stands alone without a host memory model.
module axi_sram_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  r_state_t          r_rstate, w_rstate_nxt;
  w_state_t          r_wstate, w_wstate_nxt;
  logic [DATA_W-1:0] r_mem [2**MEM_AW];
  logic [ADDR_W-1:0] r_araddr, r_awaddr;
  logic [DATA_W-1:0] r_rdata, r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_rresp, r_bresp, w_extra;
  logic [4:0]        r_rcnt, r_wcnt, w_rload, w_wload;
  logic              r_aw_got, r_w_got;
  logic              w_ar_hs, w_rd_fire, w_aw_hs, w_w_hs, w_wr_go, w_wr_fire;
  logic              w_unused;

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(32'h8000_0000) && a <= ADDR_W'(32'h87FF_FFFF)) || a == ADDR_W'(32'hA000_03F8);
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? 8'h5A : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_extra = r_lfsr[1:0];
`else
  assign w_extra = 2'b00;
`endif

  assign w_rload  = 5'(RD_LAT) + 5'(w_extra);
  assign w_wload  = 5'(WR_LAT) + 5'(w_extra);
  assign w_unused = &{1'b0, wstrb[7:4]};

  always_comb begin
    w_ar_hs      = r_rstate == R_IDLE && arvalid;
    w_rd_fire    = r_rstate == R_WAIT && r_rcnt == 5'd1;
    w_rstate_nxt = w_ar_hs ? R_WAIT : w_rd_fire ? R_RESP : (r_rstate == R_RESP && rready) ? R_IDLE : r_rstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_araddr <= araddr;
        r_rcnt   <= w_rload;
      end else if (r_rstate == R_WAIT) r_rcnt <= r_rcnt - 5'd1;
      if (w_rd_fire) begin
        r_rdata <= legal(r_araddr) ? r_mem[r_araddr[MEM_AW+1:2]] : '0;
        r_rresp <= legal(r_araddr) ? 2'b00 : 2'b11;
      end
    end
  end

  // A channel whose beat is already held counts as done, so AW and W can land in any order.
  always_comb begin
    w_aw_hs      = r_wstate == W_IDLE && !r_aw_got && awvalid;
    w_w_hs       = r_wstate == W_IDLE && !r_w_got && wvalid;
    w_wr_go      = r_wstate == W_IDLE && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
    w_wr_fire    = r_wstate == W_WAIT && r_wcnt == 5'd1;
    w_wstate_nxt = w_wr_go ? W_WAIT : w_wr_fire ? W_RESP : (r_wstate == W_RESP && bready) ? W_IDLE : r_wstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= 2'b00;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb[3:0];
      end
      r_aw_got <= !w_wr_go && (r_aw_got || w_aw_hs);
      r_w_got  <= !w_wr_go && (r_w_got || w_w_hs);
      if (w_wr_go) r_wcnt <= w_wload;
      else if (r_wstate == W_WAIT) r_wcnt <= r_wcnt - 5'd1;
      if (w_wr_fire) r_bresp <= legal(r_awaddr) ? 2'b00 : 2'b11;
    end
  end

  // The write lands only on the expiry edge, so a reset during W_WAIT leaves memory untouched.
  always_ff @(posedge clk)
    if (!rst && w_wr_fire && legal(r_awaddr))
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) r_mem[r_awaddr[MEM_AW+1:2]][8*b +: 8] <= r_wdata[8*b +: 8];

  assign arready = r_rstate == R_IDLE;
  assign rvalid  = r_rstate == R_RESP;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign awready = r_wstate == W_IDLE && !r_aw_got;
  assign wready  = r_wstate == W_IDLE && !r_w_got;
  assign bvalid  = r_wstate == W_RESP;
  assign bresp   = r_bresp;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven and scoreboarded checks of axi_sram_slave.
module tb_axi_sram_slave;
  localparam int RD_LAT = 1;
  localparam int WR_LAT = 1;
  localparam logic [40:0] RST_OUT = {5'b11100, 4'b0000, 32'h0};

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    int          skew;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [7:0]  wstrb = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b1, bready = 1'b1;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [1:0]  rresp, bresp;
  int          checks = 0, failures = 0;
  logic [33:0] sb_r[$];
  logic [1:0]  sb_b[$];
  vec_t        tbl[17];

  axi_sram_slave #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_lat(input string n, input int k, input int base);
`ifdef SRAM_RAND_DELAY_EN
    checks++;
    if (k < base || k > base + 3) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", n, k, base, base + 3);
    end
`else
    chk(n, 64'(k), 64'(base));
`endif
  endtask

  task automatic fail_stop(input string n);
    checks++;
    failures++;
    $display("FAIL %s: no response within cycle budget", n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "stopped on timeout");
  endtask

  function automatic logic [31:0] pat(input int j);
    return 32'hC0DE_0000 ^ (32'(j) * 32'h0101_0101);
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, output int k);
    logic [33:0] e;
    int n;
    sb_r.push_back({ed, er});
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready) begin
      @(negedge clk);
      if (++n > 50) fail_stop("ar_handshake");
    end
    @(posedge clk);
    k = 0;
    forever begin
      @(negedge clk);
      if (k == 0) arvalid = 1'b0;
      if (rvalid) break;
      @(posedge clk);
      if (++k > 50) fail_stop("rvalid_wait");
    end
    e = sb_r.pop_front();
    chk("rdata", 64'(rdata), 64'(e[33:2]));
    chk("rresp", 64'(rresp), 64'(e[1:0]));
    chk_lat("rd_latency", k, RD_LAT);
    @(posedge clk);
    @(negedge clk);
    chk("r_after_hs", 64'({rvalid, arready}), 64'(2'b01));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s, input int skew, input logic [1:0] er);
    bit ad = 0, wd = 0, ha, hw;
    int c = 0, k = 0;
    sb_b.push_back(er);
    while (!(ad && wd)) begin
      @(negedge clk);
      if (ad != wd) chk("ready_split", 64'({awready, wready}), 64'(ad ? 2'b01 : 2'b10));
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = !ad && c >= -skew;
      wvalid = !wd && c >= skew;
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk);
      ad = ad || ha;
      wd = wd || hw;
      if (++c > 50) fail_stop("aw_w_handshake");
    end
    forever begin
      @(negedge clk);
      if (k == 0) begin
        awvalid = 1'b0;
        wvalid = 1'b0;
      end
      if (bvalid) break;
      @(posedge clk);
      if (++k > 50) fail_stop("bvalid_wait");
    end
    chk("bresp", 64'(bresp), 64'(sb_b.pop_front()));
    chk_lat("wr_latency", k, WR_LAT);
    @(posedge clk);
    @(negedge clk);
    chk("b_after_hs", 64'({bvalid, awready, wready}), 64'(3'b011));
  endtask

  initial begin
    #2_000_000;
    fail_stop("watchdog");
  end

  initial begin
    int k, kr, kb, n;
    bit [31:0] seen;
    tbl[0]  = '{1'b1, 32'h8000_0000, 32'h0000_0413, 8'hFF,  0, 32'h0,         2'b00};
    tbl[1]  = '{1'b0, 32'h8000_0000, 32'h0,         8'h00,  0, 32'h0000_0413, 2'b00};
    tbl[2]  = '{1'b1, 32'h8000_0100, 32'h1122_3344, 8'h0F,  0, 32'h0,         2'b00};
    tbl[3]  = '{1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 8'h03,  3, 32'h0,         2'b00};
    tbl[4]  = '{1'b0, 32'h8000_0100, 32'h0,         8'h00,  0, 32'h1122_BEEF, 2'b00};
    tbl[5]  = '{1'b1, 32'h8000_0204, 32'hAABB_CCDD, 8'h0F, -1, 32'h0,         2'b00};
    tbl[6]  = '{1'b1, 32'h8000_0204, 32'hCAFE_F00D, 8'hFC, -2, 32'h0,         2'b00};
    tbl[7]  = '{1'b0, 32'h8000_0204, 32'h0,         8'h00,  0, 32'hCAFE_CCDD, 2'b00};
    tbl[8]  = '{1'b0, 32'h1000_0000, 32'h0,         8'h00,  0, 32'h0,         2'b11};
    tbl[9]  = '{1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 8'hFF,  0, 32'h0,         2'b11};
    tbl[10] = '{1'b0, 32'h8000_0000, 32'h0,         8'h00,  0, 32'h0000_0413, 2'b00};
    tbl[11] = '{1'b1, 32'hA000_03F8, 32'h0000_0041, 8'h01,  0, 32'h0,         2'b00};
    tbl[12] = '{1'b1, 32'h87FF_FFFC, 32'h5555_AAAA, 8'h0F,  1, 32'h0,         2'b00};
    tbl[13] = '{1'b0, 32'h87FF_FFFC, 32'h0,         8'h00,  0, 32'h5555_AAAA, 2'b00};
    tbl[14] = '{1'b0, 32'h8800_0000, 32'h0,         8'h00,  0, 32'h0,         2'b11};
    tbl[15] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00,  0, 32'h0,         2'b11};
    tbl[16] = '{1'b0, 32'hA000_03FC, 32'h0,         8'h00,  0, 32'h0,         2'b11};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'(RST_OUT));
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].skew, tbl[i].exp_resp);
      else do_read(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp, k);

    rready = 1'b0;
    @(negedge clk);
    chk("bp_arready_idle", 64'(arready), 64'(1'b1));
    araddr = 32'h8000_0000;
    arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid) begin
      @(negedge clk);
      if (++n > 50) fail_stop("bp_rvalid_wait");
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 64'({rvalid, arready, rresp, rdata}), 64'({1'b1, 1'b0, 2'b00, 32'h0000_0413}));
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", 64'({rvalid, arready}), 64'(2'b01));

    @(negedge clk);
    chk("conc_ready", 64'({arready, awready, wready}), 64'(3'b111));
    araddr = 32'h8000_0000;
    arvalid = 1'b1;
    awaddr = 32'h8000_0300;
    wdata = 32'h0102_0304;
    wstrb = 8'hFF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk);
    kr = -1;
    kb = -1;
    for (int c = 0; c < 40 && (kr < 0 || kb < 0); c++) begin
      @(negedge clk);
      if (c == 0) begin
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
      end
      if (rvalid && kr < 0) begin
        kr = c;
        chk("conc_rdata", 64'({rresp, rdata}), 64'({2'b00, 32'h0000_0413}));
      end
      if (bvalid && kb < 0) begin
        kb = c;
        chk("conc_bresp", 64'(bresp), 64'(2'b00));
      end
      @(posedge clk);
    end
    chk_lat("conc_rd_latency", kr, RD_LAT);
    chk_lat("conc_wr_latency", kb, WR_LAT);
    do_read(32'h8000_0300, 32'h0102_0304, 2'b00, k);

    @(negedge clk);
    araddr = 32'h8000_0000;
    arvalid = 1'b1;
    awaddr = 32'h8000_0100;
    wdata = 32'h0BAD_F00D;
    wstrb = 8'hFF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid = 1'b0;
    chk("mid_wait_busy", 64'({arready, awready, wready, bvalid}), 64'(4'b0000));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'(RST_OUT));
    rst = 1'b0;
    do_read(32'h8000_0100, 32'h1122_BEEF, 2'b00, k);

`ifdef SRAM_RAND_DELAY_EN
    for (int j = 0; j < 8; j++) do_write(32'h8000_0400 + 32'(4 * j), pat(j), 8'hFF, 0, 2'b00);
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      do_read(32'h8000_0400 + 32'(4 * (i % 8)), pat(i % 8), 2'b00, k);
      if (k >= 0 && k < 32) seen[k] = 1'b1;
    end
    chk("distinct_latencies", 64'($countones(seen) >= 2), 64'(1'b1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI-lite responder that terminates the memory bus behind the arbiter. It accepts one read and one write transaction at a time on independent channels. It services them through the `n_pmem_read` / `n_pmem_write` DPI-C functions after a configurable latency, and returns OKAY or DECERR responses. It is the slave end of the protocol driven by the IFU and LSU masters.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `RD_LAT`, 1, cycles from AR handshake to `rvalid` (legal range 1..15).
- `WR_LAT`, 1, cycles from completion of both AW and W handshakes to `bvalid` (legal range 1..15).
- Reset is `rst`, synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `araddr`  in  32  read address
- `arvalid`  in  1  read address valid
- `arready`  out  1  read address ready
- `rdata`  out  32  read data
- `rresp`  out  2  read response: 00 = OKAY, 11 = DECERR
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data accepted
- `awaddr`  in  32  write address
- `awvalid`  in  1  write address valid
- `awready`  out  1  write address ready
- `wdata`  in  32  write data
- `wstrb`  in  8  byte strobes; bits [3:0] are used, bits [7:4] are ignored
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data ready
- `bresp`  out  2  write response: 00 = OKAY, 11 = DECERR
- `bvalid`  out  1  write response valid
- `bready`  in  1  write response accepted

## Operation
- **Decode.** An address is legal if it is in 0x8000_0000..0x87FF_FFFF, or if it equals the UART address 0xA000_03F8. Any other address receives DECERR (11) and no DPI call is made. A DECERR read returns `rdata` = 0.
- **Read FSM states:**
  - `R_IDLE`: `arready` = 1. On `arvalid` && `arready`, latch `araddr`, load the delay counter, and go to `R_WAIT`.
  - `R_WAIT`: the counter decrements each cycle. When it expires, call `n_pmem_read(addr)` if the address is legal, register `rdata` and `rresp`, and go to `R_RESP`.
  - `R_RESP`: `rvalid` = 1, and `rdata`/`rresp` are held stable. On `rready`, return to `R_IDLE`.
- **Write FSM states:**
  - `W_IDLE`: `awready` = 1 until an AW beat is captured; `wready` = 1 until a W beat is captured. AW and W may arrive in either order or in the same cycle. Each channel's ready drops once that channel's beat is captured. When both are captured, load the delay counter and go to `W_WAIT`.
  - `W_WAIT`: the counter decrements each cycle. When it expires, call `n_pmem_write(addr, wdata, {4'b0, wstrb[3:0]})` exactly once if the address is legal, set `bresp`, and go to `W_RESP`.
  - `W_RESP`: `bvalid` = 1. On `bready`, return to `W_IDLE`, and `awready` and `wready` reassert in the next cycle.
- **Channel independence.** The read and write FSMs are independent and may be busy simultaneously. Ordering between a concurrent read and write is not guaranteed; the arbiter serializes dependent accesses.
- **No pipelining.** No new AR is accepted while the read FSM is in `R_WAIT` or `R_RESP`. No new AW/W beat is accepted until the previous B beat has been accepted.

## Timing
- **Reset values:** `arready` = 1, `awready` = 1, `wready` = 1, `rvalid` = 0, `bvalid` = 0, `rdata` = 0, `rresp` = 00, `bresp` = 00. Both FSMs are in their IDLE state.
- **Read latency:** AR handshake at edge N gives `rvalid` high in the cycle after edge N+`RD_LAT`. With `RD_LAT` = 1, `rvalid` is high in the second cycle after the handshake cycle.
- **Write latency:** the second of the AW/W handshakes at edge N gives `bvalid` high in the cycle after edge N+`WR_LAT`.
- **Read throughput:** `arready` returns high in the cycle after the R handshake. Minimum read period is `RD_LAT`+2 cycles.
- **Backpressure:** `rvalid`/`bvalid` are held indefinitely while `rready`/`bready` are low, and the data does not change.
- **Reset mid-transaction:** all outstanding transactions are dropped. No DPI write is issued if the FSM had not yet left `W_WAIT`.
- **Registered outputs:** all outputs come from registers; there is no combinational path from inputs to outputs.

## Configuration
- **`SRAM_RAND_DELAY_EN` defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A at reset) advances every cycle.
  - Each counter load uses `RD_LAT` (or `WR_LAT`) + `lfsr[1:0]`, giving 0..3 extra cycles.
  - Handshake rules are unchanged.
- **`SRAM_RAND_DELAY_EN` undefined:** latency is exactly `RD_LAT` / `WR_LAT`, and no LFSR is instantiated.

## Test plan
- **Single read:** with `RD_LAT` = 1 and pmem[0x8000_0000] = 0x0000_0413, drive `araddr` = 0x8000_0000 with `arvalid`, holding `rready` = 1. Required: `rvalid` is high in the second cycle after the handshake, with `rdata` = 0x0000_0413 and `rresp` = 00, for one cycle.
- **Write with AW/W skew:** drive `awvalid` (addr 0x8000_0100) 3 cycles before `wvalid` (data 0xDEADBEEF, `wstrb` = 0x3). Required:
  - `awready` drops after the AW handshake while `wready` stays high.
  - One `n_pmem_write` call is made with mask 0x03.
  - `bvalid` is high in the cycle after edge N+`WR_LAT`, where N is the W handshake edge, with `bresp` = 00.
  - A subsequent read of the same address returns 0x????BEEF, with the upper half unchanged.
- **Backpressure:** hold `rready` = 0 for 5 cycles after `rvalid` rises. Required: `rvalid`, `rdata` and `rresp` stay constant, `arready` stays 0, and `arready` returns to 1 in the cycle after `rready` is asserted.
- **Decode error:** read 0x1000_0000 and write 0x9000_0000. Required:
  - `rresp` = 11 with `rdata` = 0.
  - `bresp` = 11.
  - Zero DPI calls.
- **Concurrent read and write plus mid-transaction reset:**
  - Issue AR and AW+W in the same cycle. Required: both responses arrive with their own latencies.
  - Assert `rst` during `W_WAIT`. Required: no DPI write occurs, and all outputs return to their reset values on the next cycle.
- **`SRAM_RAND_DELAY_EN` build:** run 100 back-to-back reads. Required: every latency lies in `RD_LAT`..`RD_LAT`+3, at least two distinct latencies are observed, and every returned `rdata` matches pmem.
